// File: rtl/doppler_pkg.sv
// Shared defaults and FSM encoding for the Doppler corner-turn transmitter.
// Optional feature macro: DOPPLER_TX_TUSER_EN (adds m_tuser start-of-frame flag).
package doppler_pkg;

    localparam int DEFAULT_DATA_WIDTH = 32;
    localparam int DEFAULT_N_CHIRPS   = 16;
    localparam int DEFAULT_N_BINS     = 64;

    // FILL: accept a chirp-major frame; PRIME: first buffer read; DRAIN: bin-major output.
    typedef enum logic [1:0] {
        FILL  = 2'd0,
        PRIME = 2'd1,
        DRAIN = 2'd2
    } state_t;

endpackage

// File: rtl/doppler_corner_turn_tx_if.sv
// Frame-buffer access bus between the corner-turn controller and its RAM.
// Write and read ports are independent; rd_data is valid the cycle after rd_en.
interface doppler_corner_turn_tx_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_W     = 10
);
    logic                  wr_en;
    logic [ADDR_W-1:0]     wr_addr;
    logic [DATA_WIDTH-1:0] wr_data;
    logic                  rd_en;
    logic [ADDR_W-1:0]     rd_addr;
    logic [DATA_WIDTH-1:0] rd_data;

    modport master (output wr_en, wr_addr, wr_data, rd_en, rd_addr, input rd_data);
    modport slave  (input wr_en, wr_addr, wr_data, rd_en, rd_addr, output rd_data);
endinterface

// File: rtl/doppler_frame_ram.sv
// Simple dual-port frame buffer: one write port, one read port, registered read.
// Contents are not reset; rd_data holds its value when no read is issued.
module doppler_frame_ram #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_W     = 10
) (
    input logic                     clk,
    doppler_corner_turn_tx_if.slave bus
);
    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [DATA_WIDTH-1:0] rd_data_q;

    // Write port and registered read port.
    always_ff @(posedge clk) begin
        if (bus.wr_en) begin
            mem[bus.wr_addr] <= bus.wr_data;
        end
        if (bus.rd_en) begin
            rd_data_q <= mem[bus.rd_addr];
        end
    end

    assign bus.rd_data = rd_data_q;

endmodule

// File: rtl/doppler_corner_turn_tx.sv
// Doppler corner turn: buffers one chirp-major frame, then streams it bin-major.
// Handshake: on both s_* and m_* a beat moves only in a cycle where tvalid and
// tready are both 1; once m_tvalid is 1 it and m_tdata/m_tlast hold until taken.
// Optional feature macro: DOPPLER_TX_TUSER_EN (m_tuser marks bin 0 / chirp 0).
module doppler_corner_turn_tx
    import doppler_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int N_CHIRPS   = DEFAULT_N_CHIRPS,
    parameter int N_BINS     = DEFAULT_N_BINS
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  s_tvalid,
    output logic                  s_tready,
    input  logic [DATA_WIDTH-1:0] s_tdata,
    output logic                  m_tvalid,
    input  logic                  m_tready,
    output logic [DATA_WIDTH-1:0] m_tdata,
    output logic                  m_tlast,
`ifdef DOPPLER_TX_TUSER_EN
    output logic                  m_tuser,
`endif
    output logic                  frame_done
);
    localparam int CW = $clog2(N_CHIRPS);
    localparam int BW = $clog2(N_BINS);
    localparam int AW = CW + BW;
`ifdef DOPPLER_TX_TUSER_EN
    localparam int TAG_W = 2;   // {first, last}
`else
    localparam int TAG_W = 1;   // {last}
`endif
    localparam int EW = DATA_WIDTH + TAG_W;
    localparam logic [CW-1:0] LAST_CHIRP = CW'(N_CHIRPS - 1);
    localparam logic [BW-1:0] LAST_BIN   = BW'(N_BINS - 1);

    state_t            state_q, state_d;
    logic [BW-1:0]     wr_bin_q, wr_bin_d;
    logic [CW-1:0]     wr_chirp_q, wr_chirp_d;
    logic [BW-1:0]     rd_bin_q, rd_bin_d;
    logic [CW-1:0]     rd_chirp_q, rd_chirp_d;
    logic              rd_all_q, rd_all_d;      // every read of the frame issued
    logic              rd_pend_q, rd_pend_d;    // RAM output holds an unconsumed word
    logic [TAG_W-1:0]  rd_tag_q, rd_tag_d;
    logic [EW-1:0]     skid0_q, skid0_d;
    logic [EW-1:0]     skid1_q, skid1_d;
    logic [1:0]        skid_cnt_q, skid_cnt_d;
    logic              frame_done_q, frame_done_d;

    logic              ram_wr_en, ram_rd_en;
    logic [1:0]        occ, keep;
    logic [EW-1:0]     in_entry, head;
    logic              pop, accept;

    doppler_corner_turn_tx_if #(.DATA_WIDTH(DATA_WIDTH), .ADDR_W(AW)) ram_bus ();

    doppler_frame_ram #(.DATA_WIDTH(DATA_WIDTH), .ADDR_W(AW)) u_ram (
        .clk (clk),
        .bus (ram_bus.slave)
    );

    assign ram_bus.wr_en   = ram_wr_en;
    assign ram_bus.wr_addr = {wr_chirp_q, wr_bin_q};
    assign ram_bus.wr_data = s_tdata;
    assign ram_bus.rd_en   = ram_rd_en;
    assign ram_bus.rd_addr = {rd_chirp_q, rd_bin_q};

    // Output is the oldest skid entry, or the RAM output word when the skid is empty.
    assign in_entry = {rd_tag_q, ram_bus.rd_data};
    assign head     = (skid_cnt_q != 2'd0) ? skid0_q : in_entry;
    assign occ      = skid_cnt_q + {1'b0, rd_pend_q};
    assign m_tvalid = (occ != 2'd0);
    assign pop      = m_tvalid && m_tready;
    assign keep     = occ - {1'b0, pop};
    assign s_tready = (state_q == FILL) && !rst;
    assign accept   = s_tvalid && s_tready;

    assign m_tdata    = m_tvalid ? head[DATA_WIDTH-1:0] : '0;
    assign m_tlast    = m_tvalid && head[DATA_WIDTH];
`ifdef DOPPLER_TX_TUSER_EN
    assign m_tuser    = m_tvalid && head[DATA_WIDTH+1];
`endif
    assign frame_done = frame_done_q;

    // Next-state: write counters in FILL, read prefetch and skid bookkeeping in PRIME/DRAIN.
    always_comb begin
        state_d      = state_q;
        wr_bin_d     = wr_bin_q;
        wr_chirp_d   = wr_chirp_q;
        rd_bin_d     = rd_bin_q;
        rd_chirp_d   = rd_chirp_q;
        rd_all_d     = rd_all_q;
        rd_pend_d    = 1'b0;
        rd_tag_d     = rd_tag_q;
        skid0_d      = skid0_q;
        skid1_d      = skid1_q;
        skid_cnt_d   = keep;
        frame_done_d = 1'b0;
        ram_wr_en    = 1'b0;
        ram_rd_en    = 1'b0;

        // Any RAM word not taken directly this cycle moves behind the queued entries.
        if (pop) begin
            if (skid_cnt_q == 2'd2) begin
                skid0_d = skid1_q;
                skid1_d = in_entry;
            end else if (skid_cnt_q == 2'd1) begin
                skid0_d = in_entry;
            end
        end else if (rd_pend_q) begin
            if (skid_cnt_q == 2'd0) begin
                skid0_d = in_entry;
            end else begin
                skid1_d = in_entry;
            end
        end

        // A read is issued only if its word is guaranteed a skid slot next cycle.
        if ((state_q == PRIME) || ((state_q == DRAIN) && !rd_all_q && (keep <= 2'd1))) begin
            ram_rd_en = 1'b1;
            rd_pend_d = 1'b1;
`ifdef DOPPLER_TX_TUSER_EN
            rd_tag_d  = {(rd_chirp_q == '0) && (rd_bin_q == '0), rd_chirp_q == LAST_CHIRP};
`else
            rd_tag_d  = rd_chirp_q == LAST_CHIRP;
`endif
            if (rd_chirp_q == LAST_CHIRP) begin
                rd_chirp_d = '0;
                if (rd_bin_q == LAST_BIN) begin
                    rd_bin_d = '0;
                    rd_all_d = 1'b1;
                end else begin
                    rd_bin_d = rd_bin_q + BW'(1);
                end
            end else begin
                rd_chirp_d = rd_chirp_q + CW'(1);
            end
        end

        case (state_q)
            FILL: begin
                if (accept) begin
                    ram_wr_en = 1'b1;
                    if (wr_bin_q == LAST_BIN) begin
                        wr_bin_d = '0;
                        if (wr_chirp_q == LAST_CHIRP) begin
                            wr_chirp_d = '0;
                            state_d    = PRIME;
                        end else begin
                            wr_chirp_d = wr_chirp_q + CW'(1);
                        end
                    end else begin
                        wr_bin_d = wr_bin_q + BW'(1);
                    end
                end
            end
            PRIME: begin
                state_d = DRAIN;
            end
            DRAIN: begin
                if (pop && rd_all_q && (occ == 2'd1)) begin
                    state_d      = FILL;
                    rd_all_d     = 1'b0;
                    frame_done_d = 1'b1;
                end
            end
            default: begin
                state_d = FILL;
            end
        endcase
    end

    // State, counters and skid registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= FILL;
            wr_bin_q     <= '0;
            wr_chirp_q   <= '0;
            rd_bin_q     <= '0;
            rd_chirp_q   <= '0;
            rd_all_q     <= 1'b0;
            rd_pend_q    <= 1'b0;
            rd_tag_q     <= '0;
            skid0_q      <= '0;
            skid1_q      <= '0;
            skid_cnt_q   <= 2'd0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            wr_bin_q     <= wr_bin_d;
            wr_chirp_q   <= wr_chirp_d;
            rd_bin_q     <= rd_bin_d;
            rd_chirp_q   <= rd_chirp_d;
            rd_all_q     <= rd_all_d;
            rd_pend_q    <= rd_pend_d;
            rd_tag_q     <= rd_tag_d;
            skid0_q      <= skid0_d;
            skid1_q      <= skid1_d;
            skid_cnt_q   <= skid_cnt_d;
            frame_done_q <= frame_done_d;
        end
    end

endmodule
